keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles each column is driven; legal range 4 to 65535.
REQ-002 Parameter DEBOUNCE_FRAMES, default 4: consecutive identical scan frames needed to accept a press or release; legal range 1 to 15.
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 row_n  input  6  keypad rows; active-low, pulled up externally, asynchronous to clk.
REQ-006 col_n  output  4  keypad column drive; active-low, exactly one bit low at any time.
REQ-007 newkey  output  1  one-cycle pulse per accepted keypress.
REQ-008 keycode  output  5  code of the last accepted key; held between presses.
REQ-009 keydown  output  1  high while the accepted key is considered held.

Function
REQ-010 row_n SHALL pass through a 2-flop synchronizer before any use; synchronizer flops reset to all ones.
REQ-011 Column drive SHALL rotate col_n 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing after every SCAN_DIV cycles; one frame = 4*SCAN_DIV cycles.
REQ-012 Synchronized rows SHALL be sampled on the last cycle of each column period, recording pressed (low) rows against the active column.
REQ-013 Key at row r, column c: rows 0-3 SHALL map to keycode {1, r[1:0], c[1:0]}, giving hex value 4r+c.
REQ-014 Row 4 SHALL map to: c0 = 00001 (SUB), c1 = 00011 (CA), c2 = 00100 (EQUALS), c3 = 01001 (ADD).
REQ-015 Row 5 SHALL map to: c0 = 01010 (MULT), c1 = 01011 (BACK); c2 and c3 are unused and count as not pressed.
REQ-016 At frame end the frame SHALL be classified as NONE (0 keys), SINGLE(code) (exactly 1 key) or MULTI (2 or more keys).
REQ-017 FSM states SHALL be IDLE, DEBOUNCE and PRESSED, with a 4-bit frame counter cnt and a 5-bit candidate register cand.
REQ-018 IDLE: on SINGLE(k), set cand=k, cnt=1 and go to DEBOUNCE; on NONE or MULTI, stay in IDLE.
REQ-019 DEBOUNCE, SINGLE(cand): cnt increments; when cnt reaches DEBOUNCE_FRAMES, go to PRESSED, load keycode=cand and pulse newkey.
REQ-020 DEBOUNCE, SINGLE(k) with k != cand: set cand=k, cnt=1 and stay in DEBOUNCE.
REQ-021 DEBOUNCE, NONE or MULTI: go to IDLE with cnt=0.
REQ-022 With DEBOUNCE_FRAMES=1, the IDLE transition on SINGLE(k) SHALL go directly to PRESSED, load keycode and pulse newkey.
REQ-023 newkey SHALL be high for exactly the one cycle following the accepting frame-end evaluation; keycode SHALL be valid in that same cycle.
REQ-024 PRESSED: keydown=1; each NONE frame increments cnt; any SINGLE or MULTI frame resets cnt to 0.
REQ-025 PRESSED: when cnt reaches DEBOUNCE_FRAMES, go to IDLE, set cnt=0 and deassert keydown.
REQ-026 In PRESSED, no further newkey SHALL be generated; a second key pressed while held is ignored until a full release.
REQ-027 keydown SHALL be low in IDLE and DEBOUNCE.
REQ-028 keycode SHALL change only on a newkey cycle.
REQ-029 cnt SHALL saturate and never wrap.
REQ-030 At most one newkey pulse SHALL occur per frame.

Reset
REQ-031 On reset: col_n=1110, column cycle counter=0, state=IDLE, cnt=0, cand=0, newkey=0, keycode=00000, keydown=0.
REQ-032 Reset asserted mid-frame or in DEBOUNCE/PRESSED SHALL abort the operation without emitting newkey; scanning restarts at column 0 the cycle after reset deasserts.

Verification (SCAN_DIV=4, DEBOUNCE_FRAMES=3)
REQ-033 Hold key r2,c3 stable -> exactly one newkey pulse, keycode=11011, 3 frames (48 cycles, plus synchronizer latency) after the first frame that sees it; keydown=1 until 3 NONE frames after release.
REQ-034 Press r4,c2 bouncing (alternating NONE/SINGLE frames for 4 frames), then stable -> no newkey during bounce; newkey with keycode=00100 after 3 consecutive stable frames.
REQ-035 Press r0,c0 and r5,c0 together -> MULTI, no newkey; release r5,c0 -> newkey with keycode=10000 after 3 frames.
REQ-036 Hold r5,c1, then add r1,c1 while PRESSED -> single newkey (01011) only; keycode unchanged; release both -> keydown falls after 3 NONE frames.
REQ-037 Press r5,c3 (unused) -> no newkey, state stays IDLE.
REQ-038 Assert reset during the DEBOUNCE frame count -> no newkey, keycode=00000, col_n=1110 on the first cycle after reset.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 6-row x 4-column matrix keypad, debounces whole scan frames and
//   reports one accepted key at a time.
//
//   Parameters
//     SCAN_DIV        clock cycles each column is driven (4..65535)
//     DEBOUNCE_FRAMES identical frames needed to accept a press/release (1..15)
//
//   Ports
//     clk      in   system clock
//     reset    in   synchronous, active-high reset
//     row_n    in   [5:0] keypad rows, active-low, asynchronous to clk
//     col_n    out  [3:0] column drive, active-low, exactly one bit low
//     newkey   out  one-cycle pulse per accepted keypress
//     keycode  out  [4:0] code of the last accepted key, held between presses
//     keydown  out  high while the accepted key is considered held
//
//   The FSM state is held in the enum signal state_q so that checkers can
//   bind to it directly.
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] row_n,
  output logic [3:0] col_n,
  output logic       newkey,
  output logic [4:0] keycode,
  output logic       keydown
);

  typedef enum logic [1:0] {IDLE = 2'd0, DEBOUNCE = 2'd1, PRESSED = 2'd2} state_t;

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [4:0]  DF5      = 5'(DEBOUNCE_FRAMES);

  // Row code table: rows 0-3 are hex digits 4r+c, rows 4/5 are function keys.
  function automatic logic [4:0] key_map(input logic [2:0] r, input logic [1:0] c);
    logic [4:0] code;
    case (r)
      3'd4: begin
        case (c)
          2'd0:    code = 5'b00001;
          2'd1:    code = 5'b00011;
          2'd2:    code = 5'b00100;
          default: code = 5'b01001;
        endcase
      end
      3'd5:    code = (c == 2'd0) ? 5'b01010 : 5'b01011;
      default: code = {1'b1, r[1:0], c};
    endcase
    return code;
  endfunction

  // Two-flop synchronizer; idle (all ones) out of reset.
  logic [5:0] row_s1, row_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= row_n;
      row_s2 <= row_s1;
    end
  end

  // Column timing. col and col_n are both registered so col_n never glitches.
  logic [15:0] div_cnt;
  logic [1:0]  col;
  logic        col_end, frame_end;

  assign col_end   = (div_cnt == DIV_LAST);
  assign frame_end = col_end && (col == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      col     <= 2'd0;
      col_n   <= 4'b1110;
    end else if (col_end) begin
      div_cnt <= '0;
      col     <= col + 2'd1;
      col_n   <= {col_n[2:0], col_n[3]};
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // Keys seen in the active column. Hit counts saturate at 2 ("many").
  logic [5:0] hit;
  logic [1:0] col_hits;
  logic [4:0] col_code;

  always_comb begin
    hit      = ~row_s2;
    if (col[1]) hit[5] = 1'b0;  // row 5 has no keys in columns 2 and 3
    col_hits = 2'd0;
    col_code = 5'd0;
    for (int r = 0; r < 6; r++) begin
      if (hit[r]) begin
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
        col_code = key_map(3'(r), col);
      end
    end
  end

  // Frame accumulation across the four column samples.
  logic [1:0] acc_hits;
  logic [4:0] acc_code;
  logic [2:0] tot_sum;
  logic [1:0] tot_hits;
  logic [4:0] tot_code;

  always_comb begin
    tot_sum  = {1'b0, acc_hits} + {1'b0, col_hits};
    tot_hits = (tot_sum >= 3'd2) ? 2'd2 : tot_sum[1:0];
    tot_code = (col_hits != 2'd0) ? col_code : acc_code;
  end

  always_ff @(posedge clk) begin
    if (reset || frame_end) begin
      acc_hits <= 2'd0;
      acc_code <= 5'd0;
    end else if (col_end) begin
      acc_hits <= tot_hits;
      acc_code <= tot_code;
    end
  end

  // Debounce FSM
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] cand_q, cand_d;
  logic       accept;
  logic       newkey_q;
  logic [4:0] keycode_q;
  logic [4:0] cnt_inc;
  logic [3:0] cnt_sat;

  assign cnt_inc = {1'b0, cnt_q} + 5'd1;
  assign cnt_sat = cnt_inc[4] ? 4'hF : cnt_inc[3:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      cand_q    <= 5'd0;
      newkey_q  <= 1'b0;
      keycode_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      newkey_q <= accept;
      if (accept) keycode_q <= tot_code;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (tot_hits == 2'd1) begin
            cand_d = tot_code;
            if (DF5 == 5'd1) begin
              state_d = PRESSED;
              cnt_d   = 4'd0;
              accept  = 1'b1;
            end else begin
              state_d = DEBOUNCE;
              cnt_d   = 4'd1;
            end
          end
        end
        DEBOUNCE: begin
          if (tot_hits == 2'd1) begin
            if (tot_code == cand_q) begin
              if (cnt_inc >= DF5) begin
                state_d = PRESSED;
                cnt_d   = 4'd0;
                accept  = 1'b1;
              end else begin
                cnt_d = cnt_sat;
              end
            end else begin
              cand_d = tot_code;
              cnt_d  = 4'd1;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        end
        PRESSED: begin
          if (tot_hits == 2'd0) begin
            if (cnt_inc >= DF5) begin
              state_d = IDLE;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_sat;
            end
          end else begin
            cnt_d = 4'd0;  // any key activity restarts the release count
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    keydown = (state_q == PRESSED);
    newkey  = newkey_q;
    keycode = keycode_q;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DF       = 3;
  localparam int FRAME    = 4 * SCAN_DIV;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] row_n;
  logic [3:0] col_n;
  logic       newkey;
  logic [4:0] keycode;
  logic       keydown;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DF)) dut (
    .clk     (clk),
    .reset   (reset),
    .row_n   (row_n),
    .col_n   (col_n),
    .newkey  (newkey),
    .keycode (keycode),
    .keydown (keydown)
  );

  // Keypad emulation: key (r,c) is bit r*4+c; a held key pulls its row low
  // while its column is driven.
  logic [23:0] keys = '0;

  always_comb begin
    row_n = '1;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         t = 0;          // cycle index since reset released
  bit         m_held = 0;
  int         m_run = 0;      // consecutive identical single-key frames
  int         m_none = 0;     // consecutive empty frames while held
  logic [4:0] m_prev = '0;
  bit         exp_newkey = 0;
  logic [4:0] exp_keycode = '0;
  logic [4:0] exp_q[$];
  int         nk_count = 0;
  int         last_nk_t = -1;

  function automatic logic [4:0] code_of(input int r, input int c);
    if (r < 4) return 5'(16 + 4*r + c);
    if (r == 4) begin
      case (c)
        0:       return 5'd1;
        1:       return 5'd3;
        2:       return 5'd4;
        default: return 5'd9;
      endcase
    end
    return (c == 0) ? 5'd10 : 5'd11;
  endfunction

  task automatic model_frame();
    int         n;
    logic [4:0] code;
    n = 0;
    code = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 4; c++)
        if (!(r == 5 && c >= 2) && keys[r*4+c]) begin
          n++;
          code = code_of(r, c);
        end
    if (!m_held) begin
      if (n == 1) begin
        m_run  = (m_run > 0 && code == m_prev) ? m_run + 1 : 1;
        m_prev = code;
      end else begin
        m_run = 0;
      end
      if (m_run >= DF) begin
        m_held      = 1;
        m_run       = 0;
        m_none      = 0;
        exp_newkey  = 1;
        exp_keycode = code;
        exp_q.push_back(code);
      end
    end else begin
      m_none = (n == 0) ? m_none + 1 : 0;
      if (m_none >= DF) begin
        m_held = 0;
        m_none = 0;
        m_run  = 0;
      end
    end
  endtask

  // Model update on the active edge, comparison on the opposite edge.
  initial begin
    logic [3:0] exp_col_n;
    logic [4:0] sb_code;
    forever begin
      @(posedge clk);
      if (reset) begin
        t = 0; m_held = 0; m_run = 0; m_none = 0; m_prev = '0;
        exp_newkey = 0; exp_keycode = '0;
        exp_q.delete();
      end else begin
        exp_newkey = 0;
        if (t % FRAME == FRAME - 1) model_frame();
        t++;
      end
      @(negedge clk);
      exp_col_n = ~(4'b0001 << ((t / SCAN_DIV) % 4));
      check("col_n", int'(col_n), int'(exp_col_n));
      check("newkey", int'(newkey), int'(exp_newkey));
      check("keycode", int'(keycode), int'(exp_keycode));
      check("keydown", int'(keydown), int'(m_held));
      if (newkey) begin
        nk_count++;
        last_nk_t = t;
        if (exp_q.size() == 0) begin
          check("unexpected_newkey", 1, 0);
        end else begin
          sb_code = exp_q.pop_front();
          check("sb_keycode", int'(keycode), int'(sb_code));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    keys = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    nk_count  = 0;
    last_nk_t = -1;
  endtask

  task automatic wait_frames(input int n);
    repeat (n * FRAME) @(posedge clk);
    #1;
  endtask

  function automatic int kb(input int r, input int c);
    return r * 4 + c;
  endfunction

  // ---------------- directed tests ----------------
  initial begin
    // reset state and a stable key r2,c3
    do_reset();
    check("rst_col_n", int'(col_n), 14);
    check("rst_keycode", int'(keycode), 0);
    check("rst_keydown", int'(keydown), 0);
    keys[kb(2,3)] = 1'b1;
    wait_frames(5);
    check("t1_count", nk_count, 1);
    check("t1_time", last_nk_t, 48);
    check("t1_code", int'(keycode), 27);
    check("t1_down", int'(keydown), 1);
    keys = '0;
    wait_frames(2);
    check("t1_down_hold", int'(keydown), 1);
    wait_frames(1);
    check("t1_down_rel", int'(keydown), 0);

    // bouncing r4,c2 then stable
    do_reset();
    for (int i = 0; i < 4; i++) begin
      keys = '0;
      if (i % 2 == 0) keys[kb(4,2)] = 1'b1;
      wait_frames(1);
    end
    check("t2_bounce_count", nk_count, 0);
    keys = '0;
    keys[kb(4,2)] = 1'b1;
    wait_frames(4);
    check("t2_count", nk_count, 1);
    check("t2_code", int'(keycode), 4);
    check("t2_time", last_nk_t, 112);

    // two keys together, then one released
    do_reset();
    keys[kb(0,0)] = 1'b1;
    keys[kb(5,0)] = 1'b1;
    wait_frames(3);
    check("t3_multi_count", nk_count, 0);
    keys[kb(5,0)] = 1'b0;
    wait_frames(4);
    check("t3_count", nk_count, 1);
    check("t3_code", int'(keycode), 16);
    check("t3_time", last_nk_t, 96);

    // second key added while held is ignored
    do_reset();
    keys[kb(5,1)] = 1'b1;
    wait_frames(4);
    check("t4_count", nk_count, 1);
    check("t4_code", int'(keycode), 11);
    check("t4_time", last_nk_t, 48);
    keys[kb(1,1)] = 1'b1;
    wait_frames(3);
    check("t4_count2", nk_count, 1);
    check("t4_code2", int'(keycode), 11);
    check("t4_down", int'(keydown), 1);
    keys = '0;
    wait_frames(2);
    check("t4_down_hold", int'(keydown), 1);
    wait_frames(1);
    check("t4_down_rel", int'(keydown), 0);

    // unused position r5,c3
    do_reset();
    keys[kb(5,3)] = 1'b1;
    wait_frames(5);
    check("t5_count", nk_count, 0);
    check("t5_down", int'(keydown), 0);
    check("t5_code", int'(keycode), 0);

    // reset in the middle of debounce
    do_reset();
    keys[kb(3,0)] = 1'b1;
    wait_frames(2);
    repeat (5) @(posedge clk);
    #1;
    do_reset();
    check("t6_col_n", int'(col_n), 14);
    check("t6_code", int'(keycode), 0);
    check("t6_newkey", int'(newkey), 0);
    check("t6_down", int'(keydown), 0);
    wait_frames(3);
    check("t6_count", nk_count, 0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
